// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the hazard/forwarding logic.
package pipeline_pkg;

  localparam int HZ_REG_W            = 5;
  localparam int HZ_MULDIV_CYCLES    = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the ID source fields and the EX load destination.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_rd);
  assign rt_hit = id_uses_rt && (id_rt == ex_rd);

  // A load to $zero never produces a value worth waiting for.
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler: arbitrates memory stall, redirect, mult/div occupancy and load-use.
//   state  | meaning
//   RUN    | normal issue; front end advances unless a hazard is present
//   MULDIV | mult/div occupies EX; front end frozen until cnt reaches 0
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W         = HZ_REG_W,
  parameter int MULDIV_CYCLES = HZ_MULDIV_CYCLES,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             mem_stall,
  input  logic             branch_taken,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_is_muldiv,
  output logic             pc_write,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             muldiv_busy,
  output logic [31:0]      stall_cycles
);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_q;
  logic             load_use;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_write) stall_q <= stall_q + 32'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_freeze = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    muldiv_busy  = 1'b0;

    if (rst_b) begin
      muldiv_busy = (state_q == MULDIV);
      if (mem_stall) begin
        pc_write     = 1'b0;
        if_id_freeze = 1'b1;
        ex_hold      = 1'b1;
      end else if (state_q == RUN && branch_taken) begin
        // ID holds a wrong-path instruction, so its hazards are moot.
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (state_q == MULDIV) begin
        pc_write     = 1'b0;
        if_id_freeze = 1'b1;
        ex_hold      = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_freeze = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (id_is_muldiv) begin
        // Issue cycle plus MULDIV_CYCLES-1 frozen cycles, counted down to 0.
        state_d = MULDIV;
        cnt_d   = CNT_W'(MULDIV_CYCLES - 2);
      end
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl priorities, mult/div timing, reset abort and counter wrap.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        mem_stall, branch_taken;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, ex_mem_read, id_is_muldiv;
  logic        pc_write, if_id_freeze, if_id_flush, id_ex_bubble, ex_hold, muldiv_busy;
  logic [31:0] stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .MULDIV_CYCLES(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .mem_stall    (mem_stall),
    .branch_taken (branch_taken),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .id_is_muldiv (id_is_muldiv),
    .pc_write     (pc_write),
    .if_id_freeze (if_id_freeze),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_hold      (ex_hold),
    .muldiv_busy  (muldiv_busy),
    .stall_cycles (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Freeze and flush together would silently drop the flush in IF/ID.
  always @(negedge clk) if (!done) chk("freeze_and_flush", {31'd0, if_id_freeze & if_id_flush}, 32'd0);

  always @(posedge clk)
    if (rst_b) assert (!(muldiv_busy && branch_taken)) else $error("branch_taken while mult/div busy");

  task automatic idle();
    mem_stall = 0; branch_taken = 0; id_rs = 0; id_rt = 0; ex_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0; id_is_muldiv = 0;
  endtask

  // Apply current inputs: sample at negedge, then cross the posedge.
  task automatic step_to_neg();
    @(negedge clk);
  endtask

  task automatic step_to_pos();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_b = 0; idle();
    step_to_neg(); step_to_pos();
    rst_b = 1;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp_v);
    chk(tag, {26'd0, pc_write, if_id_freeze, if_id_flush, id_ex_bubble, ex_hold, muldiv_busy},
        {26'd0, exp_v});
  endtask

  // Output vector order: pc_write, freeze, flush, bubble, ex_hold, busy
  localparam logic [5:0] O_RUN   = 6'b100000;
  localparam logic [5:0] O_LU    = 6'b010100;
  localparam logic [5:0] O_BR    = 6'b101100;
  localparam logic [5:0] O_MS    = 6'b010010;
  localparam logic [5:0] O_MSMD  = 6'b010011;
  localparam logic [5:0] O_MD    = 6'b010011;

  initial begin
    rst_b = 0; idle();
    step_to_neg();
    chk_out("reset_outputs", O_RUN);
    chk("reset_stalls", stall_cycles, 32'd0);
    step_to_pos();
    // Outputs forced even with a cause present while in reset.
    mem_stall = 1; ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
    step_to_neg();
    chk_out("reset_forces", O_RUN);
    step_to_pos();
    rst_b = 1; idle();

    // Load-use on rs
    ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
    step_to_neg(); chk_out("lu_rs", O_LU); step_to_pos();
    idle();
    step_to_neg(); chk_out("lu_release", O_RUN); chk("lu_stalls", stall_cycles, 32'd1); step_to_pos();

    // Load to $zero
    ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    step_to_neg(); chk_out("lu_zero", O_RUN); step_to_pos();

    // rs matches but is not read -> no hazard; rt match -> hazard
    ex_mem_read = 1; ex_rd = 9; id_rs = 9; id_uses_rs = 0; id_rt = 3; id_uses_rt = 1;
    step_to_neg(); chk_out("lu_rs_unused", O_RUN); step_to_pos();
    id_rt = 9;
    step_to_neg(); chk_out("lu_rt", O_LU); step_to_pos();
    // non-load match
    ex_mem_read = 0;
    step_to_neg(); chk_out("no_load", O_RUN); chk("stalls_2", stall_cycles, 32'd2); step_to_pos();

    // Branch beats load-use and muldiv
    ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1; id_is_muldiv = 1; branch_taken = 1;
    step_to_neg(); chk_out("br_over_lu", O_BR); step_to_pos();
    idle();
    step_to_neg(); chk_out("br_no_muldiv", O_RUN); step_to_pos();

    // mem_stall beats branch
    mem_stall = 1; branch_taken = 1;
    step_to_neg(); chk_out("ms_over_br", O_MS); step_to_pos();
    idle();
    step_to_neg(); chk("stalls_3", stall_cycles, 32'd3); step_to_pos();

    // Mult/div, 4 cycles
    do_reset();
    id_is_muldiv = 1;
    step_to_neg(); chk_out("md_c0", O_RUN); step_to_pos();
    idle();
    for (int c = 1; c <= 3; c++) begin
      step_to_neg(); chk_out($sformatf("md_c%0d", c), O_MD); step_to_pos();
    end
    step_to_neg(); chk_out("md_c4", O_RUN); chk("md_stalls", stall_cycles, 32'd3); step_to_pos();

    // Mult/div with a 2-cycle memory stall at cycle 2
    do_reset();
    id_is_muldiv = 1;
    step_to_neg(); step_to_pos();
    idle();
    step_to_neg(); chk_out("mdms_c1", O_MD); step_to_pos();
    mem_stall = 1;
    step_to_neg(); chk_out("mdms_c2", O_MSMD); step_to_pos();
    step_to_neg(); chk_out("mdms_c3", O_MSMD); step_to_pos();
    mem_stall = 0;
    step_to_neg(); chk_out("mdms_c4", O_MD); step_to_pos();
    step_to_neg(); chk_out("mdms_c5", O_MD); step_to_pos();
    step_to_neg(); chk_out("mdms_c6", O_RUN); chk("mdms_stalls", stall_cycles, 32'd5); step_to_pos();

    // Reset aborts a mult/div
    do_reset();
    id_is_muldiv = 1;
    step_to_neg(); step_to_pos();
    idle();
    step_to_neg(); chk_out("rst_md_c1", O_MD); step_to_pos();
    rst_b = 0;
    step_to_neg(); chk_out("rst_md_c2", O_RUN); step_to_pos();
    rst_b = 1;
    step_to_neg(); chk_out("rst_md_c3", O_RUN); chk("rst_md_stalls", stall_cycles, 32'd0); step_to_pos();

    // Counter wrap
    step_to_neg();
    force dut.stall_q = 32'hFFFF_FFFF;
    #1 release dut.stall_q;
    #1 chk("wrap_preload", stall_cycles, 32'hFFFF_FFFF);
    step_to_pos();
    mem_stall = 1;
    step_to_neg(); step_to_pos();
    idle();
    step_to_neg(); chk("wrap_zero", stall_cycles, 32'd0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. Each cycle it decides whether the PC advances, whether the IF/ID register holds or is flushed, whether a bubble enters ID/EX, and whether the EX stage holds. It arbitrates four causes in a fixed priority:
- memory stall
- taken branch/jump
- multi-cycle mult/div
- load-use hazard

Outputs drive the freeze/flush inputs of the IF/ID register and the PC write enable directly.

Parameters:
REG_W, 5, register specifier width
MULDIV_CYCLES, 4, EX occupancy of a mult/div in cycles; legal range 2..15
CNT_W, 4, width of the mult/div down-counter; must hold MULDIV_CYCLES-1

Ports:
clk  input  1  rising-edge clock
rst_b  input  1  synchronous active-low reset; sampled on the rising edge of clk only
mem_stall  input  1  instruction or data memory not ready this cycle
branch_taken  input  1  EX-stage resolved redirect (taken branch or jump); held by its source while mem_stall=1
id_rs  input  REG_W  rs field of the instruction in ID
id_rt  input  REG_W  rt field of the instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  REG_W  destination register of the instruction in EX
id_is_muldiv  input  1  ID instruction is mult/div (enters EX next cycle)
pc_write  output  1  PC register load enable
if_id_freeze  output  1  hold IF/ID register
if_id_flush  output  1  zero IF/ID register
id_ex_bubble  output  1  load a NOP into ID/EX
ex_hold  output  1  hold ID/EX and EX/MEM, keep EX unit running
muldiv_busy  output  1  FSM in MULDIV state
stall_cycles  output  32  count of cycles with pc_write=0

Behaviour:
- The state register (RUN, MULDIV), the counter cnt[CNT_W-1:0] and stall_cycles are the only flops.
- All other outputs are combinational from state, cnt and inputs, so they act in the same cycle as their cause.
- Reset (rst_b=0 at posedge): state=RUN, cnt=0, stall_cycles=0. While rst_b=0, outputs are forced to pc_write=1 and all other outputs 0. Reset mid-MULDIV aborts immediately to RUN.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Default in RUN with no cause active: pc_write=1; all other outputs 0.
- Priority 1, mem_stall=1 (any state):
  - pc_write=0, if_id_freeze=1, ex_hold=1, if_id_flush=0, id_ex_bubble=0.
  - State and cnt are frozen.
- Priority 2, RUN & branch_taken:
  - pc_write=1, if_id_flush=1, id_ex_bubble=1, if_id_freeze=0.
  - load_use and id_is_muldiv are ignored, because the ID instruction is on the wrong path.
- Priority 3, MULDIV state:
  - pc_write=0, if_id_freeze=1, ex_hold=1.
  - cnt decrements each cycle. When cnt==0 in MULDIV, the next state is RUN and the front end releases in the following cycle.
  - branch_taken in MULDIV is illegal; the bench asserts it never occurs.
- Priority 4, RUN & load_use:
  - pc_write=0, if_id_freeze=1, id_ex_bubble=1. Exactly one stall cycle.
  - No state change; the load advances to MEM, so the hazard clears.
- Priority 5, RUN & id_is_muldiv (no hazard):
  - pc_write=1, normal advance.
  - Next state = MULDIV, cnt loaded with MULDIV_CYCLES-2.
  - The mult/div therefore occupies EX for exactly MULDIV_CYCLES cycles.
- Invariant: if_id_freeze and if_id_flush are never 1 together, because the IF/ID register gives freeze precedence and would drop the flush.
- stall_cycles increments by 1 on each posedge where rst_b=1 and pc_write=0. It wraps from 2^32-1 to 0.
- ex_rd==0 never triggers load_use (load to $zero).

Decomposition:
- Shared package (pipeline_pkg): hz_state_t enum {RUN, MULDIV}, REG_W, a NOP-encoding constant, and the default MULDIV_CYCLES.
- One natural sub-module: hazard_detect, the combinational load_use compare. It is reusable by the forwarding unit.
- The FSM, counter and priority mux stay in hazard_ctrl.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 for one cycle -> that cycle pc_write=0, if_id_freeze=1, id_ex_bubble=1. Next cycle (ex_mem_read=0) pc_write=1. stall_cycles=1.
2. Load to $zero: ex_rd=0, id_rs=0, id_uses_rs=1, ex_mem_read=1 -> no stall; pc_write=1.
3. Branch beats load-use: branch_taken=1 with a simultaneous load_use -> pc_write=1, if_id_flush=1, id_ex_bubble=1, if_id_freeze=0.
4. Mult/div, MULDIV_CYCLES=4: id_is_muldiv=1 at cycle 0 -> muldiv_busy=1 and pc_write=0 in cycles 1-3, RUN at cycle 4. stall_cycles=3.
5. mem_stall=1 for 2 cycles inserted at cycle 2 of test 4 -> cnt frozen; release moves from cycle 4 to cycle 6. stall_cycles=5. if_id_flush never asserted.
6. rst_b=0 at cycle 2 of a mult/div -> next cycle state=RUN, stall_cycles=0, pc_write=1. stall_cycles preloaded via force to 32'hFFFF_FFFF plus one stall -> reads 0.
